// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
// The control bundle holds the register-enable and flush outputs as one value.
package pipe_ctrl_pkg;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        LU_STALL = 1'b1
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_flush;
        logic pipe_freeze;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE   = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0,
                                      idex_flush: 1'b0, pipe_freeze: 1'b0};
    localparam ctrl_t CTRL_BUBBLE = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                      idex_flush: 1'b1, pipe_freeze: 1'b0};
    localparam ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                      idex_flush: 1'b0, pipe_freeze: 1'b1};
    localparam ctrl_t CTRL_FLUSH  = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1,
                                      idex_flush: 1'b1, pipe_freeze: 1'b0};

    // A load in EX whose destination is read by the instruction in ID; r0 never hazards.
    function automatic logic load_use_hazard(input logic       mem_read,
                                             input logic [4:0] load_rt,
                                             input logic [4:0] rs,
                                             input logic [4:0] rt,
                                             input logic       uses_rt);
        return mem_read && (load_rt != REG_ZERO) &&
               ((load_rt == rs) || (uses_rt && (load_rt == rt)));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
// Updates on the falling edge to match the pipeline registers.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, branch/jump flushes and
// data-memory freezes, plus stall/flush counters and a sticky timeout flag.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int LOAD_USE_BUBBLES = 1,
    parameter int MEM_TIMEOUT      = 255,
    parameter int CNT_W            = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             ex_branch_taken,
    input  logic             ex_jump,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             pipe_freeze,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam logic [2:0]  BUB_INIT = 3'(LOAD_USE_BUBBLES - 1);
    localparam logic [15:0] BUSY_LIM = 16'(MEM_TIMEOUT);

    state_t      state, state_next;
    logic [2:0]  bub_cnt, bub_next;
    logic [15:0] busy_cnt, busy_next;
    ctrl_t       ctrl;
    logic        flush_evt;
    logic        hazard_lu;

    assign hazard_lu = load_use_hazard(ex_mem_read, ex_rt, id_rs, id_rt, id_uses_rt);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        ctrl       = CTRL_IDLE;
        state_next = state;
        bub_next   = bub_cnt;
        flush_evt  = 1'b0;
        if (reset) begin
            ctrl = CTRL_IDLE;
        end else if (mem_busy) begin
            ctrl = CTRL_FREEZE;
        end else if (ex_branch_taken || ex_jump) begin
            ctrl       = CTRL_FLUSH;
            state_next = RUN;
            bub_next   = 3'd0;
            flush_evt  = 1'b1;
        end else if (state == LU_STALL) begin
            ctrl     = CTRL_BUBBLE;
            bub_next = bub_cnt - 3'd1;
            if (bub_cnt == 3'd1) begin
                state_next = RUN;
            end
        end else if (hazard_lu) begin
            ctrl = CTRL_BUBBLE;
            if (LOAD_USE_BUBBLES > 1) begin
                state_next = LU_STALL;
                bub_next   = BUB_INIT;
            end
        end
    end

    // The busy run length saturates so a very long wait cannot wrap below the limit.
    always_comb begin
        busy_next = 16'd0;
        if (mem_busy) begin
            busy_next = (busy_cnt == 16'hFFFF) ? busy_cnt : busy_cnt + 16'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            bub_cnt     <= 3'd0;
            busy_cnt    <= 16'd0;
            mem_timeout <= 1'b0;
        end else begin
            state    <= state_next;
            bub_cnt  <= bub_next;
            busy_cnt <= busy_next;
            if (mem_busy && (busy_next >= BUSY_LIM)) begin
                mem_timeout <= 1'b1;
            end
        end
    end

    assign pc_write    = ctrl.pc_write;
    assign ifid_write  = ctrl.ifid_write;
    assign ifid_flush  = ctrl.ifid_flush;
    assign idex_flush  = ctrl.idex_flush;
    assign pipe_freeze = ctrl.pipe_freeze;

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (!ctrl.pc_write),
        .count (stall_cycles)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_evt),
        .count (flush_events)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: instance a uses default parameters, instance b uses
// LOAD_USE_BUBBLES=3, MEM_TIMEOUT=4, CNT_W=3; both share the same stimulus.
module tb_pipe_hazard_ctrl;

    // Control bundle order: {pc_write, ifid_write, ifid_flush, idex_flush, pipe_freeze}
    localparam logic [4:0] IDLE = 5'b11000;
    localparam logic [4:0] BUB  = 5'b00010;
    localparam logic [4:0] FRZ  = 5'b00001;
    localparam logic [4:0] FLS  = 5'b11110;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rt, ex_mem_read, ex_branch_taken, ex_jump, mem_busy;

    logic        a_pc_write, a_ifid_write, a_ifid_flush, a_idex_flush, a_pipe_freeze, a_timeout;
    logic [15:0] a_stall, a_flush;
    logic        b_pc_write, b_ifid_write, b_ifid_flush, b_idex_flush, b_pipe_freeze, b_timeout;
    logic [2:0]  b_stall, b_flush;
    logic [4:0]  a_ctrl, b_ctrl;

    int n_cmp = 0;
    int n_bad = 0;

    assign a_ctrl = {a_pc_write, a_ifid_write, a_ifid_flush, a_idex_flush, a_pipe_freeze};
    assign b_ctrl = {b_pc_write, b_ifid_write, b_ifid_flush, b_idex_flush, b_pipe_freeze};

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut_a (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
        .ex_jump(ex_jump), .mem_busy(mem_busy), .pc_write(a_pc_write),
        .ifid_write(a_ifid_write), .ifid_flush(a_ifid_flush), .idex_flush(a_idex_flush),
        .pipe_freeze(a_pipe_freeze), .mem_timeout(a_timeout), .stall_cycles(a_stall),
        .flush_events(a_flush)
    );

    pipe_hazard_ctrl #(.LOAD_USE_BUBBLES(3), .MEM_TIMEOUT(4), .CNT_W(3)) dut_b (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
        .ex_jump(ex_jump), .mem_busy(mem_busy), .pc_write(b_pc_write),
        .ifid_write(b_ifid_write), .ifid_flush(b_ifid_flush), .idex_flush(b_idex_flush),
        .pipe_freeze(b_pipe_freeze), .mem_timeout(b_timeout), .stall_cycles(b_stall),
        .flush_events(b_flush)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                         input logic [4:0] rt, input logic urt, input logic br,
                         input logic jp, input logic busy);
        ex_mem_read     = mr;
        ex_rt           = ert;
        id_rs           = rs;
        id_rt           = rt;
        id_uses_rt      = urt;
        ex_branch_taken = br;
        ex_jump         = jp;
        mem_busy        = busy;
    endtask

    // Inputs change 1 time unit after the rising edge; the active (falling) edge is 5 later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        #3;
        check("rst_idle_a", a_ctrl, IDLE);
        check("rst_idle_b", b_ctrl, IDLE);
        check("rst_stall_a", a_stall, 0);
        check("rst_flush_a", a_flush, 0);
        check("rst_timeout_a", a_timeout, 0);
        mem_busy = 1'b0;
        next_cycle();
        reset = 1'b0;

        // Load-use on rs, one cycle
        drive(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); #2;
        check("lu_rs_bubble", a_ctrl, BUB);
        next_cycle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); #2;
        check("lu_cleared_idle", a_ctrl, IDLE);
        check("lu_stall_cnt", a_stall, 1);
        next_cycle();

        // No hazard: r0 target, rt match without rt use; then rt match with use
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0); #2;
        check("rt_zero_idle", a_ctrl, IDLE);
        next_cycle();
        drive(1'b1, 5'd8, 5'd3, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0); #2;
        check("rt_unused_idle", a_ctrl, IDLE);
        next_cycle();
        drive(1'b0, 5'd8, 5'd8, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0); #2;
        check("no_memread_idle", a_ctrl, IDLE);
        next_cycle();
        drive(1'b1, 5'd8, 5'd3, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0); #2;
        check("rt_used_bubble", a_ctrl, BUB);
        next_cycle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); #2;
        check("rt_stall_cnt", a_stall, 2);
        next_cycle();

        // Branch wins over load-use; jump alone; mem_busy wins over jump
        drive(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0); #2;
        check("branch_over_lu", a_ctrl, FLS);
        next_cycle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); #2;
        check("branch_flush_cnt", a_flush, 1);
        check("branch_no_stall", a_stall, 2);
        next_cycle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0); #2;
        check("jump_flush", a_ctrl, FLS);
        next_cycle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1); #2;
        check("busy_over_jump", a_ctrl, FRZ);
        next_cycle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); #2;
        check("jump_flush_cnt", a_flush, 2);
        check("freeze_stall_cnt", a_stall, 3);
        check("timeout_a_quiet", a_timeout, 0);
        reset = 1'b1; #1;
        check("async_clr_stall_a", a_stall, 0);
        check("async_clr_flush_a", a_flush, 0);
        next_cycle();
        reset = 1'b0;

        // Three bubbles interrupted by a two-cycle freeze
        drive(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); #2;
        check("b_lu_first", b_ctrl, BUB);
        next_cycle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1); #2;
        check("b_frz1", b_ctrl, FRZ);
        next_cycle(); #2;
        check("b_frz2", b_ctrl, FRZ);
        next_cycle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); #2;
        check("b_resume1", b_ctrl, BUB);
        next_cycle(); #2;
        check("b_resume2", b_ctrl, BUB);
        next_cycle(); #2;
        check("b_done_idle", b_ctrl, IDLE);
        check("b_stall_cnt5", b_stall, 5);
        next_cycle();

        // Six busy cycles against a limit of four; stall counter saturates at 7
        for (int k = 1; k <= 6; k++) begin
            drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1); #2;
            check($sformatf("b_busy_frz%0d", k), b_ctrl, FRZ);
            check($sformatf("b_busy_tmo%0d", k), b_timeout, (k >= 5) ? 1 : 0);
            next_cycle();
        end
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); #2;
        check("b_after_busy_idle", b_ctrl, IDLE);
        check("b_tmo_sticky", b_timeout, 1);
        check("b_stall_sat", b_stall, 7);
        check("a_tmo_not_reached", a_timeout, 0);
        next_cycle(); #2;
        check("b_tmo_sticky2", b_timeout, 1);
        next_cycle();

        // Reset mid-LU_STALL clears everything at once
        drive(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); #2;
        check("b_lu_again", b_ctrl, BUB);
        next_cycle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); #2;
        check("b_lustall_cont", b_ctrl, BUB);
        reset = 1'b1; #1;
        check("b_rst_ctrl_idle", b_ctrl, IDLE);
        check("b_rst_stall", b_stall, 0);
        check("b_rst_flush", b_flush, 0);
        check("b_rst_tmo", b_timeout, 0);
        next_cycle();
        reset = 1'b0; #2;
        check("b_run_after_rst", b_ctrl, IDLE);
        next_cycle();

        // Reset during a freeze forces idle outputs
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1); #2;
        check("b_frz_pre_rst", b_ctrl, FRZ);
        reset = 1'b1; #1;
        check("b_rst_over_busy", b_ctrl, IDLE);
        next_cycle();
        reset = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); #2;
        check("b_idle_end", b_ctrl, IDLE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
